// File: rtl/seq_pkg.sv
// Shared encodings and parameter bounds for the debouncer and the downstream
// four-state sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHK_HI    = 2'b01,
    STABLE_HI = 2'b11,
    CHK_LO    = 2'b10
  } deb_state_e;

  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;
  localparam int DEBOUNCE_CYCLES_MIN = 2;
  localparam int DEBOUNCE_CYCLES_MAX = 65535;

endpackage

// File: rtl/input_debouncer_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input; q is the
// last stage and the only one downstream logic may use.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Button/switch debouncer: synchronizes raw_in, accepts a level change only
// after DEBOUNCE_CYCLES identical samples, and emits one-cycle edge pulses.
module input_debouncer
  import seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_in,
  output logic       level_out,
  output logic       press_pulse,
  output logic       release_pulse,
  output deb_state_e dbg_state
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          raw_eff;
  logic          sync_q;
  deb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;

  assign raw_eff = ACTIVE_LOW ? ~raw_in : raw_in;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (raw_eff),
    .q    (sync_q)
  );

  // Pulses default low every cycle so each acceptance yields exactly one
  // cycle; cnt counts samples of the candidate level, including the first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        STABLE_LO: begin
          if (sync_q) begin
            state_q <= CHK_HI;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        CHK_HI: begin
          if (!sync_q) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync_q) begin
            state_q <= CHK_LO;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        CHK_LO: begin
          if (sync_q) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign level_out     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign dbg_state     = state_q;

endmodule
